round_sequencer: RTL and testbench

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer_pkg.sv | 33 +++
 rtl/round_sequencer_press_latch.sv | 40 ++++
 rtl/round_sequencer.sv | 120 ++++++++++++
 tb/tb_round_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/round_sequencer_pkg.sv
// rtl/round_sequencer_pkg.sv - shared states, action codes and defaults for the round sequencer
package round_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_SETTLE,
        ST_OVER
    } state_t;

    localparam int ACT_W                 = 6;
    localparam int DEFAULT_TIMEOUT_TICKS = 8;

    localparam logic [2:0] ACT_NONE = 3'd0;
    localparam logic [2:0] ACT_BTN0 = 3'd1;
    localparam logic [2:0] ACT_BTN1 = 3'd2;
    localparam logic [2:0] ACT_BTN2 = 3'd3;
    localparam logic [2:0] ACT_BTN3 = 3'd4;
    localparam logic [2:0] ACT_BTN4 = 3'd5;
    localparam logic [2:0] ACT_BTN5 = 3'd6;

    // Lowest set bit wins; code is bit index + 1, ACT_NONE when no bit is set.
    function automatic logic [2:0] act_encode(input logic [ACT_W-1:0] bits);
        logic [2:0] code;
        code = ACT_NONE;
        for (int i = ACT_W - 1; i >= 0; i--) begin
            if (bits[i]) code = 3'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/round_sequencer_press_latch.sv
// rtl/round_sequencer_press_latch.sv - per-player rising-edge press detect with first-press-per-round latch
module press_latch
    import round_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ACT_W-1:0] act,
    input  logic             en,
    input  logic             clr,
    output logic             latched_next,
    output logic [2:0]       code_next
);

    logic [ACT_W-1:0] prev;
    logic [ACT_W-1:0] rise;
    logic             latched;
    logic [2:0]       code;
    logic             take;

    // Next-state values are exported so the round can complete in the press cycle itself.
    always_comb begin
        rise         = act & ~prev;
        take         = en && !latched && (|rise);
        latched_next = latched || take;
        code_next    = take ? act_encode(rise) : code;
    end

    // prev follows act even in reset so buttons held through reset never read as presses.
    always_ff @(posedge clk) begin
        prev <= act;
        if (rst || clr) begin
            latched <= 1'b0;
            code    <= ACT_NONE;
        end else begin
            latched <= latched_next;
            code    <= code_next;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - two-player round FSM: collect presses, issue both commands, watch for loss
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    parameter int TICK_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sw,
    input  logic [ACT_W-1:0] plr_1_act,
    input  logic [ACT_W-1:0] plr_2_act,
    input  logic             plr_1_lst,
    input  logic             plr_2_lst,
    output logic [2:0]       plr_1_cmd,
    output logic [2:0]       plr_2_cmd,
    output logic             cmd_vld,
    output logic             turn,
    output logic [3:0]       rnd_cnt,
    output logic             game_over
);

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              mode_sim;
    logic              p1_en;
    logic              p2_en;
    logic              latch_clr;
    logic              p1_done;
    logic              p2_done;
    logic [2:0]        p1_code;
    logic [2:0]        p2_code;
    logic              round_done;
    logic              timeout;

    always_comb begin
        p1_en      = (state == ST_COLLECT) && (mode_sim || !turn);
        p2_en      = (state == ST_COLLECT) && (mode_sim || turn);
        latch_clr  = (state == ST_IDLE) || (state == ST_SETTLE);
        round_done = mode_sim ? (p1_done && p2_done) : (turn ? p2_done : p1_done);
        timeout    = tick && (tick_cnt == TICK_W'(TIMEOUT_TICKS - 1));
    end

    press_latch u_p1 (
        .clk          (clk),
        .rst          (rst),
        .act          (plr_1_act),
        .en           (p1_en),
        .clr          (latch_clr),
        .latched_next (p1_done),
        .code_next    (p1_code)
    );

    press_latch u_p2 (
        .clk          (clk),
        .rst          (rst),
        .act          (plr_2_act),
        .en           (p2_en),
        .clr          (latch_clr),
        .latched_next (p2_done),
        .code_next    (p2_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            plr_1_cmd <= ACT_NONE;
            plr_2_cmd <= ACT_NONE;
            cmd_vld   <= 1'b0;
            turn      <= 1'b0;
            rnd_cnt   <= 4'd0;
            game_over <= 1'b0;
            tick_cnt  <= '0;
            mode_sim  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_COLLECT;
                    tick_cnt <= '0;
                    mode_sim <= sw;
                end
                ST_COLLECT: begin
                    // Commands are captured from the latch next-values so a completing press is included.
                    if (round_done || timeout) begin
                        state     <= ST_ISSUE;
                        cmd_vld   <= 1'b1;
                        plr_1_cmd <= p1_code;
                        plr_2_cmd <= p2_code;
                        rnd_cnt   <= rnd_cnt + 4'd1;
                        if (!mode_sim) turn <= ~turn;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cmd_vld <= 1'b0;
                    state   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (plr_1_lst || plr_2_lst) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state    <= ST_COLLECT;
                        tick_cnt <= '0;
                        mode_sim <= sw;
                    end
                end
                ST_OVER: begin
                    state <= ST_OVER;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - self-checking bench for round_sequencer against a round-level reference model
module tb_round_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       sw;
    logic [5:0] p1_act;
    logic [5:0] p2_act;
    logic       lst1;
    logic       lst2;
    logic [2:0] plr_1_cmd;
    logic [2:0] plr_2_cmd;
    logic       cmd_vld;
    logic       turn;
    logic [3:0] rnd_cnt;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: round bookkeeping with a countdown of dead cycles between rounds.
    logic [5:0] prev1, prev2;
    bit m_vld, m_turn, m_over, m_collect, m_after, m_mode;
    int m_cmd1, m_cmd2, m_rnd, m_wait, m_got1, m_got2, m_ticks;

    round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .sw        (sw),
        .plr_1_act (p1_act),
        .plr_2_act (p2_act),
        .plr_1_lst (lst1),
        .plr_2_lst (lst2),
        .plr_1_cmd (plr_1_cmd),
        .plr_2_cmd (plr_2_cmd),
        .cmd_vld   (cmd_vld),
        .turn      (turn),
        .rnd_cnt   (rnd_cnt),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest_press(input logic [5:0] rise);
        for (int k = 0; k < 6; k++) begin
            if (rise[k]) return k + 1;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [5:0] r1, r2;
        int c1, c2;
        bit done;
        if (rst) begin
            m_vld = 0; m_cmd1 = 0; m_cmd2 = 0; m_turn = 0; m_rnd = 0; m_over = 0;
            m_collect = 0; m_wait = 1; m_after = 0; m_mode = 0;
            prev1 = p1_act; prev2 = p2_act;
            return;
        end
        r1 = p1_act & ~prev1;
        r2 = p2_act & ~prev2;
        prev1 = p1_act;
        prev2 = p2_act;
        m_vld = 0;
        if (m_over) return;
        if (m_collect) begin
            c1 = lowest_press(r1);
            c2 = lowest_press(r2);
            if (c1 != 0 && m_got1 == 0 && (m_mode || !m_turn)) m_got1 = c1;
            if (c2 != 0 && m_got2 == 0 && (m_mode || m_turn)) m_got2 = c2;
            if (tick) m_ticks++;
            done = m_mode ? (m_got1 != 0 && m_got2 != 0) : (m_turn ? m_got2 != 0 : m_got1 != 0);
            if (done || m_ticks >= TO) begin
                m_cmd1 = m_got1; m_cmd2 = m_got2; m_vld = 1;
                m_rnd = (m_rnd + 1) % 16;
                if (!m_mode) m_turn = !m_turn;
                m_collect = 0; m_wait = 2; m_after = 1;
            end
        end else if (m_wait == 1 && m_after && (lst1 || lst2)) begin
            m_over = 1;
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_collect = 1; m_got1 = 0; m_got2 = 0; m_ticks = 0; m_mode = sw;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("vld",   int'(cmd_vld),   int'(m_vld));
        check_eq("cmd1",  int'(plr_1_cmd), m_cmd1);
        check_eq("cmd2",  int'(plr_2_cmd), m_cmd2);
        check_eq("turn",  int'(turn),      int'(m_turn));
        check_eq("rnd",   int'(rnd_cnt),   m_rnd);
        check_eq("over",  int'(game_over), int'(m_over));
    endtask

    task automatic clear_inputs();
        tick = 0; p1_act = 0; p2_act = 0; lst1 = 0; lst2 = 0;
    endtask

    task automatic do_reset();
        rst = 1; cycle();
        rst = 0; cycle();
    endtask

    initial begin
        rst = 1; sw = 0;
        clear_inputs();
        cycle();
        check_eq("rst_vld", int'(cmd_vld), 0);
        check_eq("rst_rnd", int'(rnd_cnt), 0);

        // Simultaneous mode, presses five cycles apart.
        sw = 1; do_reset();
        p1_act = 6'b000100; cycle();
        repeat (4) cycle();
        check_eq("r35_wait_vld", int'(cmd_vld), 0);
        p2_act = 6'b000001; cycle();
        check_eq("r35_vld",  int'(cmd_vld),   1);
        check_eq("r35_cmd1", int'(plr_1_cmd), 3);
        check_eq("r35_cmd2", int'(plr_2_cmd), 1);
        check_eq("r35_rnd",  int'(rnd_cnt),   1);
        cycle();
        check_eq("r35_vld_drop", int'(cmd_vld), 0);
        check_eq("r35_cmd_hold", int'(plr_1_cmd), 3);

        // Alternating mode: off-turn player is ignored.
        clear_inputs(); sw = 0; do_reset();
        p2_act = 6'b000010; cycle();
        p1_act = 6'b100000; cycle();
        check_eq("r36_vld",  int'(cmd_vld),   1);
        check_eq("r36_cmd1", int'(plr_1_cmd), 6);
        check_eq("r36_cmd2", int'(plr_2_cmd), 0);
        check_eq("r36_turn", int'(turn),      1);

        // Timeout with only player 2 latched.
        clear_inputs(); sw = 1; do_reset();
        p2_act = 6'b000010; cycle();
        for (int i = 0; i < TO; i++) begin
            tick = 1; cycle();
            tick = 0;
            if (i < TO - 1) begin
                check_eq("r37_early_vld", int'(cmd_vld), 0);
                cycle();
            end
        end
        check_eq("r37_vld",  int'(cmd_vld),   1);
        check_eq("r37_cmd1", int'(plr_1_cmd), 0);
        check_eq("r37_cmd2", int'(plr_2_cmd), 2);

        // Multi-bit press encodes lowest; second press in the round ignored.
        clear_inputs(); sw = 1; do_reset();
        p1_act = 6'b010100; cycle();
        p1_act = 6'b110100; cycle();
        p2_act = 6'b001000; cycle();
        check_eq("r38_vld",  int'(cmd_vld),   1);
        check_eq("r38_cmd1", int'(plr_1_cmd), 3);
        check_eq("r38_cmd2", int'(plr_2_cmd), 4);

        // Loss during settle freezes the game; reset recovers.
        clear_inputs(); sw = 1; do_reset();
        p1_act = 6'b000001; p2_act = 6'b000001; cycle();
        check_eq("r39_issue", int'(cmd_vld), 1);
        lst2 = 1; cycle(); cycle();
        lst2 = 0;
        check_eq("r39_over", int'(game_over), 1);
        for (int i = 0; i < 20; i++) begin
            p1_act = 6'(1 << (i % 6)); p2_act = 6'(1 << ((i + 3) % 6)); cycle();
            check_eq("r39_frozen_vld", int'(cmd_vld), 0);
        end
        rst = 1; cycle();
        rst = 0;
        check_eq("r39_rst_over", int'(game_over), 0);
        check_eq("r39_rst_cmd1", int'(plr_1_cmd), 0);
        check_eq("r39_rst_turn", int'(turn),      0);

        // Seventeen rounds wrap the counter to 1.
        clear_inputs(); sw = 1; do_reset();
        for (int r = 0; r < 17; r++) begin
            p1_act = 6'b000001; p2_act = 6'b000001; cycle();
            p1_act = 0; p2_act = 0; cycle(); cycle();
        end
        check_eq("r40_wrap", int'(rnd_cnt), 1);
        p1_act = 6'b001000; rst = 1; cycle();
        rst = 0; cycle();
        p2_act = 6'b000001;
        repeat (3) begin
            cycle();
            check_eq("r40_held_vld", int'(cmd_vld), 0);
        end

        // Randomised traffic against the model.
        clear_inputs(); sw = 0; do_reset();
        for (int i = 0; i < 2500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) sw = ~sw;
            if ($urandom_range(0, 3) == 0) p1_act = p1_act ^ 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) p2_act = p2_act ^ 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) p1_act = 6'($urandom);
            lst1 = ($urandom_range(0, 59) == 0);
            lst2 = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
